// File: rtl/oam_dma_pkg.sv
// Shared types and sizing for the sprite DMA controller.
// Holds the FSM state encoding and the OAM copy geometry.
package dma_pkg;

   localparam int C_oam_len   = 256;
   localparam int C_page_bits = 8;
   localparam int C_idx_bits  = $clog2(C_oam_len);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE,
      DONE
   } t_dma_state;

endpackage

// File: rtl/oam_dma_if.sv
// Host-side and CPU-bus signals of the sprite DMA.
// master = the DMA block, slave = the widget top level.
interface oam_dma_if;

   logic [15:0] I_host_addr;
   logic        I_host_rdwr;
   logic [7:0]  I_host_wr_data;
   logic [7:0]  I_rd_data;
   logic        O_halt;
   logic        O_bus_own;
   logic [15:0] O_addr;
   logic        O_rdwr;
   logic [7:0]  O_wr_data;
   logic        O_busy;

   modport master (
      input  I_host_addr,
      input  I_host_rdwr,
      input  I_host_wr_data,
      input  I_rd_data,
      output O_halt,
      output O_bus_own,
      output O_addr,
      output O_rdwr,
      output O_wr_data,
      output O_busy
   );

   modport slave (
      output I_host_addr,
      output I_host_rdwr,
      output I_host_wr_data,
      output I_rd_data,
      input  O_halt,
      input  O_bus_own,
      input  O_addr,
      input  O_rdwr,
      input  O_wr_data,
      input  O_busy
   );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a host write to the trigger address stalls the core
// and copies one 256-byte page to the OAM data port.
module oam_dma
   import dma_pkg::*;
#(
   parameter logic [15:0] P_trigger_addr = 16'h4014,
   parameter logic [15:0] P_target_addr  = 16'h2004
) (
   input  logic       I_clock,
   input  logic       I_reset,
   input  logic       I_tick,
   oam_dma_if.master  bus
);

   localparam logic [C_idx_bits-1:0] C_last = C_idx_bits'(C_oam_len - 1);

   t_dma_state             state;
   logic [C_page_bits-1:0] page;
   logic [C_idx_bits-1:0]  index;
   logic                   parity;
   logic                   halt;
   logic                   own;
   logic [15:0]            addr;
   logic                   rdwr;
   logic [7:0]             wr_data;
   logic                   busy;

   assign bus.O_halt    = halt;
   assign bus.O_bus_own = own;
   assign bus.O_addr    = addr;
   assign bus.O_rdwr    = rdwr;
   assign bus.O_wr_data = wr_data;
   assign bus.O_busy    = busy;

   // Parity clock, transfer FSM and registered bus outputs, all per CPU cycle.
   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         state   <= IDLE;
         page    <= '0;
         index   <= '0;
         parity  <= 1'b0;
         halt    <= 1'b0;
         own     <= 1'b0;
         addr    <= '0;
         rdwr    <= 1'b1;
         wr_data <= '0;
         busy    <= 1'b0;
      end else if (I_tick) begin
         parity <= ~parity;
         unique case (state)
            IDLE: begin
               if (!own && !bus.I_host_rdwr &&
                   bus.I_host_addr == P_trigger_addr) begin
                  page  <= bus.I_host_wr_data;
                  state <= HALT;
                  halt  <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            HALT: begin
               // RDY only takes effect on a core read; that read is the
               // halt cycle. A GET halt cycle forces one dummy PUT first.
               if (bus.I_host_rdwr) begin
                  own  <= 1'b1;
                  rdwr <= 1'b1;
                  if (!parity) begin
                     state <= ALIGN;
                     addr  <= P_target_addr;
                  end else begin
                     state <= READ;
                     addr  <= {page, index};
                  end
               end
            end
            ALIGN: begin
               state <= READ;
               rdwr  <= 1'b1;
               addr  <= {page, index};
            end
            READ: begin
               wr_data <= bus.I_rd_data;
               state   <= WRITE;
               rdwr    <= 1'b0;
               addr    <= P_target_addr;
            end
            WRITE: begin
               if (index == C_last) begin
                  state <= IDLE;
                  index <= '0;
                  own   <= 1'b0;
                  halt  <= 1'b0;
                  busy  <= 1'b0;
                  rdwr  <= 1'b1;
                  addr  <= '0;
               end else begin
                  state <= READ;
                  index <= index + 1'b1;
                  rdwr  <= 1'b1;
                  addr  <= {page, index + 1'b1};
               end
            end
            DONE: begin
               state <= IDLE;
               index <= '0;
               own   <= 1'b0;
               halt  <= 1'b0;
               busy  <= 1'b0;
               rdwr  <= 1'b1;
               addr  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
